// File: rtl/sync_fifo_v5.sv
// Single-clock FIFO with arbitrary depth, occupancy count, threshold flags,
// optional show-ahead read port, synchronous flush and sticky error flags.
module sync_fifo_v5 #(
  parameter int unsigned DEPTH     = 4,
  parameter type         T         = logic,
  parameter bit          FWFT      = 1'b0,
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned AE_THRESH = 1,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          clr_err,
  input  logic          wen,
  input  T              data_in,
  input  logic          ren,
  output T              data_out,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  T              mem_q [DEPTH];
  logic [AW-1:0] waddr_q, waddr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;

  // Flags come from the count register only, so wen/ren never reach them.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wen & ~full & ~flush;
  assign rd_acc = ren & ~empty & ~flush;

  always_comb begin
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
    if (wr_acc) waddr_d = (waddr_q == LastAddr) ? '0 : waddr_q + AW'(1);
    if (rd_acc) raddr_d = (raddr_q == LastAddr) ? '0 : raddr_q + AW'(1);
    if (flush) begin
      waddr_d = '0;
      raddr_d = '0;
      count_d = '0;
    end
  end

  // Set wins over clear when both happen in the same cycle.
  always_comb begin
    ovf_d = (wen & full & ~flush) | (ovf_q & ~clr_err);
    unf_d = (ren & empty & ~flush) | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_q <= '0;
      raddr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr_q] <= data_in;
  end

  if (FWFT) begin : g_fwft
    assign data_out = empty ? T'('0) : mem_q[raddr_q];
  end else begin : g_reg
    T dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout_q <= T'('0);
      else if (rd_acc) dout_q <= mem_q[raddr_q];
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_v5.sv
// Randomised and directed bench for sync_fifo_v5: registered and show-ahead
// instances share one stimulus stream and are checked against a queue model.
module tb_sync_fifo_v5;

  localparam int unsigned Depth = 5;
  typedef logic [7:0] byte_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       clr_err = 1'b0;
  logic       wen = 1'b0;
  logic       ren = 1'b0;
  byte_t      data_in = '0;

  byte_t      dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] cnt0, cnt1;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  // Reference model
  byte_t q[$];
  byte_t m_dout;
  bit    m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_v5 #(.DEPTH(Depth), .T(byte_t), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .wen(wen),
    .data_in(data_in), .ren(ren), .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ovf0),
    .underflow(unf0)
  );

  sync_fifo_v5 #(.DEPTH(Depth), .T(byte_t), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err), .wen(wen),
    .data_in(data_in), .ren(ren), .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ovf1),
    .underflow(unf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endfunction

  // One clock edge of the FIFO's documented behaviour.
  function automatic void model_step(bit w, byte_t d, bit r, bit fl, bit clr);
    bit is_full  = (q.size() == Depth);
    bit is_empty = (q.size() == 0);
    m_ovf = (w && is_full && !fl) || (m_ovf && !clr);
    m_unf = (r && is_empty && !fl) || (m_unf && !clr);
    if (fl) begin
      q.delete();
    end else begin
      if (r && !is_empty) m_dout = q.pop_front();
      if (w && !is_full) q.push_back(d);
    end
  endfunction

  task automatic check_all(input string tag);
    int unsigned n = q.size();
    byte_t head = (n != 0) ? q[0] : 8'h00;
    check_eq({tag, ".count0"}, 32'(cnt0), n);
    check_eq({tag, ".count1"}, 32'(cnt1), n);
    check_eq({tag, ".full"}, {30'd0, full0, full1}, {30'd0, n == Depth, n == Depth});
    check_eq({tag, ".empty"}, {30'd0, empty0, empty1}, {30'd0, n == 0, n == 0});
    check_eq({tag, ".afull"}, {30'd0, af0, af1}, {30'd0, n >= Depth - 1, n >= Depth - 1});
    check_eq({tag, ".aempty"}, {30'd0, ae0, ae1}, {30'd0, n <= 1, n <= 1});
    check_eq({tag, ".ovf"}, {30'd0, ovf0, ovf1}, {30'd0, m_ovf, m_ovf});
    check_eq({tag, ".unf"}, {30'd0, unf0, unf1}, {30'd0, m_unf, m_unf});
    check_eq({tag, ".dout_reg"}, 32'(dout0), 32'(m_dout));
    check_eq({tag, ".dout_fwft"}, 32'(dout1), 32'(head));
  endtask

  task automatic cycle(input string tag, input bit w, input byte_t d, input bit r,
                       input bit fl = 1'b0, input bit clr = 1'b0);
    wen = w; data_in = d; ren = r; flush = fl; clr_err = clr;
    @(posedge clk);
    model_step(w, d, r, fl, clr);
    #1;
    check_all(tag);
    wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full, then one rejected write.
    for (int i = 0; i < 5; i++) cycle("fill", 1'b1, 8'h10 + 8'(i), 1'b0);
    cycle("ovf", 1'b1, 8'hEE, 1'b0);
    check_eq("ovf_set", 32'(ovf0), 32'd1);

    // Drain, then one rejected read; registered data must hold 0x14.
    for (int i = 0; i < 5; i++) begin
      cycle("drain", 1'b0, 8'h00, 1'b1);
      check_eq("drain_order", 32'(dout0), 32'h10 + 32'(i));
    end
    cycle("unf", 1'b0, 8'h00, 1'b1);
    check_eq("unf_hold", 32'(dout0), 32'h14);
    cycle("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Pointer wrap on a non-power-of-two depth.
    cycle("wrap_w0", 1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 12; i++) begin
      cycle("wrap", 1'b1, 8'(i), 1'b1);
      check_eq("wrap_order", 32'(dout0), 32'(i - 1));
    end
    cycle("wrap_last", 1'b0, 8'h00, 1'b1);
    check_eq("wrap_final", 32'(dout0), 32'h0B);

    // Show-ahead presentation and read-with-write.
    cycle("fwft_w", 1'b1, 8'hA5, 1'b0);
    check_eq("fwft_a5", 32'(dout1), 32'hA5);
    cycle("fwft_rw", 1'b1, 8'h5A, 1'b1);
    check_eq("fwft_5a", 32'(dout1), 32'h5A);
    cycle("fwft_pop", 1'b0, 8'h00, 1'b1);

    // Flush with simultaneous wen/ren.
    for (int i = 0; i < 3; i++) cycle("fl_load", 1'b1, 8'h30 + 8'(i), 1'b0);
    cycle("flush", 1'b1, 8'h99, 1'b1, 1'b1);
    check_eq("flush_cnt", 32'(cnt0), 32'd0);
    cycle("fl_w77", 1'b1, 8'h77, 1'b0);
    cycle("fl_r77", 1'b0, 8'h00, 1'b1);
    check_eq("flush_rd", 32'(dout0), 32'h77);

    // Set-wins error clear.
    for (int i = 0; i < 5; i++) cycle("err_fill", 1'b1, 8'h40 + 8'(i), 1'b0);
    cycle("clr_set", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    check_eq("clr_setwins", 32'(ovf0), 32'd1);
    cycle("clr_only", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("clr_cleared", 32'(ovf0), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit w = ($urandom_range(0, 99) < 55);
      bit r = ($urandom_range(0, 99) < 50);
      bit fl = ($urandom_range(0, 99) < 3);
      bit clr = ($urandom_range(0, 99) < 5);
      cycle("rand", w, 8'($urandom), r, fl, clr);
    end

    // Asynchronous reset mid-transfer, away from any edge.
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 8'hC0 + 8'(i), 1'b0);
    cycle("pre_rst_rd", 1'b1, 8'hC3, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 8'h5C, 1'b0);
    cycle("post_rst_rd", 1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
